// File: rtl/frame_draw_scheduler_pkg.sv
// Shared types and constants for the snake game drawing path.
// Holds the draw-phase state enum, bus widths and the on-screen range check.
package snake_pkg;

  localparam int COLOUR_W     = 3;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SNAKE,
    FOOD
  } state_t;

  function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int w, input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_clear_scanner.sv
// Raster x/y generator for the per-frame screen clear.
// With FRAME_DRAW_BORDER_EN defined, edge pixels get BORDER_COLOUR instead of BG_COLOUR.
module clear_scanner
  import snake_pkg::*;
#(
  parameter int                  SCREEN_W      = DEF_SCREEN_W,
  parameter int                  SCREEN_H      = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000,
  parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                advance,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic                last,
  output logic [COLOUR_W-1:0] colour
);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  // x runs fastest; the scan wraps to the origin after the final pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

`ifdef FRAME_DRAW_BORDER_EN
  logic on_border;
  assign on_border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
  assign colour    = on_border ? BORDER_COLOUR : BG_COLOUR;
`else
  assign colour = BG_COLOUR;
`endif

endmodule

// File: rtl/frame_draw_scheduler.sv
// Owns the VGA adapter write port: per frame tick runs CLEAR, then SNAKE, then FOOD.
// Optional macro FRAME_DRAW_BORDER_EN draws a BORDER_COLOUR frame during CLEAR.
module frame_draw_scheduler
  import snake_pkg::*;
#(
  parameter int                  SCREEN_W      = DEF_SCREEN_W,
  parameter int                  SCREEN_H      = DEF_SCREEN_H,
  parameter int                  FRAME_CYCLES  = 25_000_000,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000,
  parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                snake_valid,
  input  logic [X_W-1:0]      snake_x,
  input  logic [Y_W-1:0]      snake_y,
  input  logic [COLOUR_W-1:0] snake_colour,
  input  logic                snake_last,
  output logic                snake_ready,
  input  logic                food_valid,
  input  logic [X_W-1:0]      food_x,
  input  logic [Y_W-1:0]      food_y,
  input  logic [COLOUR_W-1:0] food_colour,
  input  logic                food_last,
  output logic                food_ready,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                frame_done,
  output logic                overrun,
  output logic                busy
);

  // One extra count of headroom so FRAME_CYCLES itself is representable.
  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);

  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  state_t              state, next_state;
  logic                scan_start, scan_advance, scan_last;
  logic [X_W-1:0]      scan_x;
  logic [Y_W-1:0]      scan_y;
  logic [COLOUR_W-1:0] scan_colour;
  logic                snake_hs, food_hs;

  assign tick = (tick_cnt == CNT_W'(FRAME_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  clear_scanner #(
    .SCREEN_W     (SCREEN_W),
    .SCREEN_H     (SCREEN_H),
    .BG_COLOUR    (BG_COLOUR),
    .BORDER_COLOUR(BORDER_COLOUR)
  ) u_scanner (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (scan_start),
    .advance(scan_advance),
    .x      (scan_x),
    .y      (scan_y),
    .last   (scan_last),
    .colour (scan_colour)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    scan_start   = 1'b0;
    scan_advance = 1'b0;
    snake_ready  = 1'b0;
    food_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          next_state = CLEAR;
          scan_start = 1'b1;
        end
      end
      CLEAR: begin
        scan_advance = 1'b1;
        if (scan_last) next_state = SNAKE;
      end
      SNAKE: begin
        snake_ready = 1'b1;
        if (snake_valid && snake_last) next_state = FOOD;
      end
      FOOD: begin
        food_ready = 1'b1;
        if (food_valid && food_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign snake_hs = snake_valid && snake_ready;
  assign food_hs  = food_valid && food_ready;

  // Off-screen requester pixels still complete their handshake but never reach the adapter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vga_plot   <= 1'b0;
      frame_done <= 1'b0;
      if (tick && (state != IDLE)) overrun <= 1'b1;
      if (state == CLEAR) begin
        vga_x      <= scan_x;
        vga_y      <= scan_y;
        vga_colour <= scan_colour;
        vga_plot   <= 1'b1;
      end else if (snake_hs) begin
        if (in_screen(snake_x, snake_y, SCREEN_W, SCREEN_H)) begin
          vga_x      <= snake_x;
          vga_y      <= snake_y;
          vga_colour <= snake_colour;
          vga_plot   <= 1'b1;
        end
      end else if (food_hs) begin
        if (in_screen(food_x, food_y, SCREEN_W, SCREEN_H)) begin
          vga_x      <= food_x;
          vga_y      <= food_y;
          vga_colour <= food_colour;
          vga_plot   <= 1'b1;
        end
        frame_done <= food_last;
      end
    end
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Scoreboard bench for frame_draw_scheduler on a 4x3 screen with a 40-cycle frame.
// Honours FRAME_DRAW_BORDER_EN when choosing expected clear colours.
module tb_frame_draw_scheduler;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FC = 40;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       snake_valid = 1'b0, snake_last = 1'b0, food_valid = 1'b0, food_last = 1'b0;
  logic [7:0] snake_x = '0, food_x = '0, vga_x;
  logic [6:0] snake_y = '0, food_y = '0, vga_y;
  logic [2:0] snake_colour = '0, food_colour = '0, vga_colour;
  logic       snake_ready, food_ready, vga_plot, frame_done, overrun, busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  pix_t sb[$];

  frame_draw_scheduler #(
    .SCREEN_W    (W),
    .SCREEN_H    (H),
    .FRAME_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .snake_valid (snake_valid),
    .snake_x     (snake_x),
    .snake_y     (snake_y),
    .snake_colour(snake_colour),
    .snake_last  (snake_last),
    .snake_ready (snake_ready),
    .food_valid  (food_valid),
    .food_x      (food_x),
    .food_y      (food_y),
    .food_colour (food_colour),
    .food_last   (food_last),
    .food_ready  (food_ready),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] clear_colour(input int x, input int y);
`ifdef FRAME_DRAW_BORDER_EN
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 3'b111;
    return 3'b000;
`else
    return 3'b000;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic push_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back({8'(x), 7'(y), clear_colour(x, y)});
  endtask

  task automatic applyStimulus(input bit is_snake, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] c, input logic last);
    if (is_snake) begin
      snake_valid = 1'b1; snake_x = x; snake_y = y; snake_colour = c; snake_last = last;
    end else begin
      food_valid = 1'b1; food_x = x; food_y = y; food_colour = c; food_last = last;
    end
    if (int'(x) < W && int'(y) < H) sb.push_back({x, y, c});
  endtask

  // Every adapter write must match the oldest outstanding expectation.
  always @(posedge clk) begin
    pix_t got, exp;
    #1;
    if (reset_n && vga_plot === 1'b1) begin
      got = {vga_x, vga_y, vga_colour};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $error("[TB] FAIL unexpected_plot observed=%0h expected=none", got);
      end else begin
        exp = sb.pop_front();
        assert (got === exp)
        else begin
          failures++;
          $error("[TB] FAIL plot_pixel observed=%0h expected=%0h", got, exp);
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    checkOutput("reset_plot", vga_plot, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_snake_ready", snake_ready, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    push_clear();
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;

    // Frame 1: clear, three snake pixels with a gap, one food pixel.
    run_to(39);
    checkOutput("pre_tick_busy", busy, 0);
    run_to(40);
    checkOutput("tick_busy", busy, 1);
    checkOutput("tick_no_plot", vga_plot, 0);
    for (int k = 41; k <= 52; k++) begin
      run_to(k);
      checkOutput("clear_plot_run", vga_plot, 1);
    end
    checkOutput("clear_to_snake_ready", snake_ready, 1);
    checkOutput("clear_food_ready", food_ready, 0);
    checkOutput("clear_sb_empty", sb.size(), 0);
    food_valid = 1'b1; food_x = 8'd0; food_y = 7'd0; food_colour = 3'd7; food_last = 1'b1;
    applyStimulus(1'b1, 8'd1, 7'd2, 3'd2, 1'b0);
    step();
    applyStimulus(1'b1, 8'd2, 7'd0, 3'd5, 1'b0);
    step();
    snake_valid = 1'b0;
    step();
    checkOutput("gap_no_plot", vga_plot, 0);
    applyStimulus(1'b1, 8'd3, 7'd1, 3'd6, 1'b1);
    step();
    snake_valid = 1'b0;
    checkOutput("snake_done_ready", snake_ready, 0);
    checkOutput("food_phase_ready", food_ready, 1);
    checkOutput("food_phase_frame_done", frame_done, 0);
    applyStimulus(1'b0, 8'd2, 7'd2, 3'd4, 1'b1);
    step();
    food_valid = 1'b0;
    checkOutput("frame_done_pulse", frame_done, 1);
    checkOutput("frame_end_busy", busy, 0);
    step();
    checkOutput("frame_done_single", frame_done, 0);
    checkOutput("frame1_sb_empty", sb.size(), 0);

    // Frame 2: stall snake past the next tick, then an off-screen last pixel.
    push_clear();
    run_to(80);
    checkOutput("frame2_busy", busy, 1);
    run_to(92);
    checkOutput("frame2_snake_ready", snake_ready, 1);
    run_to(119);
    checkOutput("pre_overrun", overrun, 0);
    run_to(120);
    checkOutput("overrun_set", overrun, 1);
    run_to(121);
    checkOutput("overrun_no_restart", snake_ready, 1);
    checkOutput("overrun_no_plot", vga_plot, 0);
    applyStimulus(1'b1, 8'd4, 7'd0, 3'd3, 1'b1);
    step();
    snake_valid = 1'b0;
    checkOutput("oob_no_plot", vga_plot, 0);
    checkOutput("oob_to_food", food_ready, 1);
    applyStimulus(1'b0, 8'd0, 7'd1, 3'd1, 1'b1);
    step();
    food_valid = 1'b0;
    checkOutput("frame2_done", frame_done, 1);
    step();
    checkOutput("overrun_sticky", overrun, 1);
    checkOutput("frame2_sb_empty", sb.size(), 0);

    // Frame 3: reset lands on the fifth clear pixel.
    push_clear();
    run_to(165);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_plot", vga_plot, 0);
    checkOutput("midreset_y", vga_y, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_overrun", overrun, 0);
    checkOutput("midreset_frame_done", frame_done, 0);
    sb.delete();
    push_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    lat = 0;
    while (vga_plot !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    checkOutput("restart_latency", lat, FC + 1);
    run_to(52);
    checkOutput("restart_snake_ready", snake_ready, 1);
    checkOutput("restart_sb_empty", sb.size(), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Owns the single write port of the VGA adapter and shares it between three requesters in a fixed per-frame order: screen clear, snake body, food.
- Generates the frame tick internally and runs one sequence per tick: CLEAR (internal raster scanner), SNAKE (external requester), FOOD (external requester).
- Pulses `frame_done` to the game logic when the sequence finishes.
- Sits between the game-logic drawers and the vga_adapter write inputs.

Parameters:
- SCREEN_W, 160, pixels per row; x range 0..SCREEN_W-1.
- SCREEN_H, 120, rows; y range 0..SCREEN_H-1.
- FRAME_CYCLES, 25_000_000, clk cycles per frame tick; minimum 2.
- BG_COLOUR, 3'b000, colour written during CLEAR.
- BORDER_COLOUR, 3'b111, border colour; used only with BORDER_EN.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous, active-low reset.
- snake_valid, input, 1, snake pixel request.
- snake_x, input, 8, snake pixel x.
- snake_y, input, 7, snake pixel y.
- snake_colour, input, 3, snake pixel colour.
- snake_last, input, 1, qualifies the final snake pixel of this frame.
- snake_ready, output, 1, snake pixel accepted this cycle when valid.
- food_valid, input, 1, food pixel request.
- food_x, input, 8, food pixel x.
- food_y, input, 7, food pixel y.
- food_colour, input, 3, food pixel colour.
- food_last, input, 1, qualifies the final food pixel of this frame.
- food_ready, output, 1, food pixel accepted this cycle when valid.
- vga_x, output, 8, adapter x.
- vga_y, output, 7, adapter y.
- vga_colour, output, 3, adapter colour.
- vga_plot, output, 1, adapter write enable.
- frame_done, output, 1, one-cycle pulse when the FOOD phase completes.
- overrun, output, 1, sticky flag: a tick arrived while not IDLE.
- busy, output, 1, high in any state other than IDLE.

Behaviour:

Reset:
- reset_n is asynchronous, active-low; clock is clk.
- On reset: state=IDLE, tick counter=0, scan x/y=0, all outputs 0.
- Reset mid-frame aborts the sequence immediately. There is no partial completion and no frame_done pulse.

Tick counter:
- Counts 0..FRAME_CYCLES-1 and wraps to 0.
- tick=1 when count==FRAME_CYCLES-1.
- The counter width is derived with $clog2. No truncation is allowed: the counter must hold 25_000_000.

State machine:
- IDLE: on tick go to CLEAR, with scan x=0, y=0.
- CLEAR: emit one pixel per cycle, raster order, x fastest.
  - At x==SCREEN_W-1, set x=0 and y=y+1.
  - After pixel (SCREEN_W-1, SCREEN_H-1) go to SNAKE.
  - The pixel count is exactly SCREEN_W*SCREEN_H; (SCREEN_W, y) and (x, SCREEN_H) are never emitted.
- SNAKE:
  - snake_ready=1 combinationally while in SNAKE; food_ready=0.
  - A handshake (valid&ready) captures x/y/colour.
  - A handshake with snake_last=1 moves to FOOD on the next cycle.
  - valid low means the state waits indefinitely.
- FOOD: same rules using the food_* ports. A handshake with food_last=1 moves to IDLE and pulses frame_done the next cycle.
- A tick while busy sets overrun=1 (sticky until reset) and is discarded. It does not queue or restart the sequence.

Output timing:
- All vga_* outputs are registered: one cycle latency from the CLEAR emission or the handshake.
- vga_plot=0 in all other cycles; vga_x/y/colour hold their last value.

Boundary rules:
- Out-of-range requester pixel (x>=SCREEN_W or y>=SCREEN_H): the handshake completes and _last is honoured, but vga_plot stays 0.
- Only the active phase's requester receives ready; the other's valid is ignored.
- The CLEAR→SNAKE transition has no gap. The cycle after the last clear pixel, snake_ready=1.

Optional Feature:
- Macro: FRAME_DRAW_BORDER_EN.
- Defined: during CLEAR, pixels with x==0, x==SCREEN_W-1, y==0 or y==SCREEN_H-1 use BORDER_COLOUR; all others use BG_COLOUR.
- Undefined: every CLEAR pixel uses BG_COLOUR and the BORDER_COLOUR parameter is unused.

Decomposition:
- Shared package snake_pkg:
  - state enum: IDLE, CLEAR, SNAKE, FOOD.
  - COLOUR_W=3, X_W=8, Y_W=7.
  - Default SCREEN_W/SCREEN_H constants.
- Sub-module clear_scanner:
  - Raster x/y generator with start, advance and last outputs.
  - Parameterised by SCREEN_W/SCREEN_H.
  - The border decode lives inside it under the macro.
- Tick counter and FSM stay in the top module.

Test Plan:
- Reset and first tick (SCREEN_W=4, SCREEN_H=3, FRAME_CYCLES=40): tick at cycle 39 → 12 consecutive vga_plot cycles; coords (0,0),(1,0)..(3,2); colour 0; then snake_ready=1.
- Snake then food handshakes (same params): snake sends 3 pixels with last on the 3rd and a one-cycle valid gap → 3 plots with matching coords/colour; food sends 1 pixel with last → 1 plot; frame_done pulses once; busy=0.
- Out-of-range pixel: snake pixel (4,0) with last → accepted, no vga_plot, state advances to FOOD.
- Overrun: hold snake_valid low past the next tick (cycle 79) → overrun=1 and stays 1; the sequence continues and the tick is not replayed.
- Reset mid-CLEAR: assert reset_n=0 at the 5th pixel → all outputs 0 immediately; after release, no plot until the next full tick period (40 cycles).
- FRAME_DRAW_BORDER_EN defined (SCREEN_W=4, SCREEN_H=3): only pixels (1,1) and (2,1) are BG_COLOUR; the other 10 are 3'b111.
